// File: rtl/char_glyph_packer.sv
// Packs a raster pixel stream for one character cell into a 5x8 block glyph (bit = row*5 + col).
// Define CHAR_GLYPH_PACKER_ERRCNT_EN to count mid-cell SOF resyncs on err_cnt.
module char_glyph_packer #(
    parameter int BLK_W  = 4,
    parameter int BLK_H  = 4,
    parameter int THRESH = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_data,
    input  logic        pix_sof,
    output logic        glyph_valid,
    input  logic        glyph_ready,
    output logic [39:0] glyph_data,
    output logic [7:0]  err_cnt
);

    localparam int IW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int RW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int AW = $clog2(BLK_W * BLK_H + 1);
    localparam logic [IW-1:0] IC_LAST = IW'(BLK_W - 1);
    localparam logic [RW-1:0] IR_LAST = RW'(BLK_H - 1);
    localparam logic [AW-1:0] TH      = AW'(THRESH);

    // Position is tracked as (block, offset-in-block) pairs so no division is needed.
    logic [IW-1:0] in_col, e_in_col, n_in_col;
    logic [RW-1:0] in_row, e_in_row, n_in_row;
    logic [2:0]    blk_col, e_blk_col, n_blk_col;
    logic [2:0]    blk_row, e_blk_row, n_blk_row;
    logic [AW-1:0] acc [5];
    logic [AW-1:0] sum;
    logic [39:0]   shadow;
    logic [5:0]    bit_idx;
    logic          blk_bit, blk_last, cell_last, at_last, accept;

    assign at_last   = (in_col == IC_LAST) && (blk_col == 3'd4) &&
                       (in_row == IR_LAST) && (blk_row == 3'd7);
    assign pix_ready = !ARESET && !(glyph_valid && !glyph_ready && at_last);
    assign accept    = pix_valid && pix_ready;

    // An SOF beat is treated as pixel (0,0) regardless of where the counters were.
    always_comb begin
        e_in_col  = pix_sof ? '0 : in_col;
        e_in_row  = pix_sof ? '0 : in_row;
        e_blk_col = pix_sof ? '0 : blk_col;
        e_blk_row = pix_sof ? '0 : blk_row;
        blk_last  = (e_in_col == IC_LAST) && (e_in_row == IR_LAST);
        cell_last = blk_last && (e_blk_col == 3'd4) && (e_blk_row == 3'd7);
        sum       = (pix_sof ? '0 : acc[e_blk_col]) + AW'(pix_data);
        blk_bit   = (sum >= TH);
        bit_idx   = 6'(e_blk_row) * 6'd5 + 6'(e_blk_col);

        n_in_col  = e_in_col;
        n_in_row  = e_in_row;
        n_blk_col = e_blk_col;
        n_blk_row = e_blk_row;
        if (e_in_col != IC_LAST) begin
            n_in_col = e_in_col + 1'b1;
        end else begin
            n_in_col = '0;
            if (e_blk_col != 3'd4) begin
                n_blk_col = e_blk_col + 3'd1;
            end else begin
                n_blk_col = '0;
                if (e_in_row != IR_LAST) begin
                    n_in_row = e_in_row + 1'b1;
                end else begin
                    n_in_row  = '0;
                    n_blk_row = (e_blk_row == 3'd7) ? 3'd0 : e_blk_row + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            in_col  <= '0;
            in_row  <= '0;
            blk_col <= '0;
            blk_row <= '0;
            shadow  <= '0;
            for (int k = 0; k < 5; k++) acc[k] <= '0;
        end else if (accept) begin
            in_col  <= n_in_col;
            in_row  <= n_in_row;
            blk_col <= n_blk_col;
            blk_row <= n_blk_row;
            if (pix_sof) begin
                for (int k = 0; k < 5; k++) acc[k] <= '0;
            end
            acc[e_blk_col] <= blk_last ? '0 : sum;
            if (pix_sof || cell_last) shadow <= '0;
            if (blk_last && !cell_last) shadow[bit_idx] <= blk_bit;
        end
    end

    // The last block's bit is merged straight into the output so the glyph loads in one edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            glyph_valid <= 1'b0;
            glyph_data  <= '0;
        end else if (accept && cell_last) begin
            glyph_valid <= 1'b1;
            glyph_data  <= {blk_bit, shadow[38:0]};
        end else if (glyph_ready) begin
            glyph_valid <= 1'b0;
        end
    end

`ifdef CHAR_GLYPH_PACKER_ERRCNT_EN
    logic [7:0] err_q;
    logic       at_origin;

    assign at_origin = (in_col == '0) && (in_row == '0) && (blk_col == '0) && (blk_row == '0);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_q <= '0;
        end else if (accept && pix_sof && !at_origin && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_char_glyph_packer.sv
// Self-checking bench for char_glyph_packer: vector table plus hand sequences for
// backpressure, resync and reset; THRESH=8 and THRESH=7 instances share one stimulus.
`timescale 1ns/1ps
module tb_char_glyph_packer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_data = 1'b0;
    logic        pix_sof = 1'b0;
    logic        glyph_ready = 1'b0;
    logic        pix_ready0, pix_ready1, gv0, gv1;
    logic [39:0] gd0, gd1;
    logic [7:0]  ec0, ec1;

    int          total = 0;
    int          bad = 0;
    logic [39:0] q0[$];
    logic [39:0] q1[$];
    bit          rnd[640];

    localparam logic [39:0] ALL1   = 40'hFF_FFFF_FFFF;
    localparam logic [39:0] TOPBOT = 40'hF8_0000_001F;
`ifdef CHAR_GLYPH_PACKER_ERRCNT_EN
    localparam logic [39:0] ERR1 = 40'd1;
    localparam logic [39:0] ERR2 = 40'd2;
`else
    localparam logic [39:0] ERR1 = 40'd0;
    localparam logic [39:0] ERR2 = 40'd0;
`endif

    typedef struct {
        int          pat;
        bit          sof;
        logic [39:0] e8;
        logic [39:0] e7;
        bit          use_model;
    } vec_t;

    vec_t vecs[6];

    always #5 ACLK = ~ACLK;

    char_glyph_packer #(.BLK_W(4), .BLK_H(4), .THRESH(8)) dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .pix_valid(pix_valid), .pix_ready(pix_ready0),
        .pix_data(pix_data), .pix_sof(pix_sof), .glyph_valid(gv0), .glyph_ready(glyph_ready),
        .glyph_data(gd0), .err_cnt(ec0)
    );

    char_glyph_packer #(.BLK_W(4), .BLK_H(4), .THRESH(7)) dut1 (
        .ACLK(ACLK), .ARESET(ARESET), .pix_valid(pix_valid), .pix_ready(pix_ready1),
        .pix_data(pix_data), .pix_sof(pix_sof), .glyph_valid(gv1), .glyph_ready(glyph_ready),
        .glyph_data(gd1), .err_cnt(ec1)
    );

    function automatic bit pix_val(int pat, int col, int row);
        case (pat)
            0:       return 1'b1;
            1:       return (row == 0 && col < 8) || (row == 1 && col < 7);
            2:       return (row < 4) || (row >= 28);
            3:       return rnd[row * 20 + col];
            4:       return ((col + row) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [39:0] model(int pat, int th);
        logic [39:0] res = '0;
        for (int br = 0; br < 8; br++) begin
            for (int bc = 0; bc < 5; bc++) begin
                int cnt = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        cnt += int'(pix_val(pat, bc * 4 + c, br * 4 + r));
                res[br * 5 + bc] = (cnt >= th);
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [39:0] got, input logic [39:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Drives one beat and returns once it has been accepted; entered and left at posedge+1.
    task automatic applyStimulus(input bit d, input bit sof, output int waited);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        waited    = 0;
        @(negedge ACLK);
        while (!pix_ready0 && waited < 200) begin
            waited++;
            @(negedge ACLK);
        end
        if (!pix_ready0) checkOutput("beat accept timeout", 40'(waited), 40'd0);
        @(posedge ACLK);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic sendCell(input int pat, input bit sof, input logic [39:0] e0, input logic [39:0] e1);
        int w;
        q0.push_back(e0);
        q1.push_back(e1);
        for (int idx = 0; idx < 640; idx++)
            applyStimulus(pix_val(pat, idx % 20, idx / 20), sof && (idx == 0), w);
        checkOutput("valid one cycle after last beat", {39'b0, gv0}, 40'd1);
    endtask

    task automatic sendOnes(input int n);
        int w;
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, w);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int stalls;

        // Scoreboard consumer: a glyph transfers on the next edge when valid && ready.
        fork
            forever begin
                @(negedge ACLK);
                if (!ARESET && glyph_ready) begin
                    if (gv0) begin
                        if (q0.size() == 0) begin
                            total++; bad++;
                            $display("[TB] FAIL unexpected glyph0 got=%h want=none", gd0);
                        end else checkOutput("glyph0", gd0, q0.pop_front());
                    end
                    if (gv1) begin
                        if (q1.size() == 0) begin
                            total++; bad++;
                            $display("[TB] FAIL unexpected glyph1 got=%h want=none", gd1);
                        end else checkOutput("glyph1", gd1, q1.pop_front());
                    end
                end
            end
        join_none

        vecs[0] = '{0, 1'b1, ALL1, ALL1, 1'b0};
        vecs[1] = '{1, 1'b1, 40'h00_0000_0001, 40'h00_0000_0003, 1'b0};
        vecs[2] = '{2, 1'b0, TOPBOT, TOPBOT, 1'b0};
        vecs[3] = '{4, 1'b0, ALL1, ALL1, 1'b0};
        vecs[4] = '{3, 1'b1, 40'h0, 40'h0, 1'b1};
        vecs[5] = '{3, 1'b0, 40'h0, 40'h0, 1'b1};

        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("reset pix_ready", {39'b0, pix_ready0}, 40'd0);
        checkOutput("reset glyph_valid", {39'b0, gv0}, 40'd0);
        checkOutput("reset glyph_data", gd0, 40'd0);
        checkOutput("reset err_cnt", {32'b0, ec0}, 40'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        checkOutput("pix_ready idle", {39'b0, pix_ready0}, 40'd1);
        glyph_ready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            logic [39:0] e8, e7;
            if (vecs[v].pat == 3)
                for (int i = 0; i < 640; i++) rnd[i] = 1'($urandom_range(0, 1));
            e8 = vecs[v].e8;
            e7 = vecs[v].e7;
            if (vecs[v].use_model) begin
                e8 = model(vecs[v].pat, 8);
                e7 = model(vecs[v].pat, 7);
            end
            sendCell(vecs[v].pat, vecs[v].sof, e8, e7);
            checkOutput("err_cnt clean cell", {32'b0, ec0}, 40'd0);
        end

        // Backpressure: glyph 1 waits while glyph 2 streams in and stalls on its last pixel.
        @(posedge ACLK); #1;
        glyph_ready = 1'b0;
        sendCell(0, 1'b1, ALL1, ALL1);
        q0.push_back(TOPBOT);
        q1.push_back(TOPBOT);
        stalls = 0;
        for (int idx = 0; idx < 639; idx++) begin
            applyStimulus(pix_val(2, idx % 20, idx / 20), 1'b0, w);
            stalls += w;
        end
        checkOutput("no stall before last pixel", 40'(stalls), 40'd0);
        pix_valid = 1'b1;
        pix_data  = pix_val(2, 19, 31);
        pix_sof   = 1'b0;
        @(negedge ACLK);
        checkOutput("stall at last pixel", {39'b0, pix_ready0}, 40'd0);
        @(negedge ACLK);
        checkOutput("still stalled", {39'b0, pix_ready0}, 40'd0);
        checkOutput("glyph1 held dut0", gd0, ALL1);
        checkOutput("glyph1 held dut1", gd1, ALL1);
        @(posedge ACLK); #1;
        glyph_ready = 1'b1;
        @(negedge ACLK);
        checkOutput("ready follows glyph_ready", {39'b0, pix_ready0}, 40'd1);
        @(posedge ACLK); #1;
        pix_valid   = 1'b0;
        glyph_ready = 1'b0;
        checkOutput("no bubble valid", {39'b0, gv0}, 40'd1);
        checkOutput("glyph2 loaded", gd0, TOPBOT);
        glyph_ready = 1'b1;
        @(posedge ACLK); #1;

        // Mid-cell resync at pixel 100, then SOF landing on the last-pixel position.
        for (int i = 0; i < 640; i++) rnd[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 100; i++) applyStimulus(rnd[i], 1'b0, w);
        sendCell(0, 1'b1, ALL1, ALL1);
        checkOutput("err_cnt after resync", {32'b0, ec0}, ERR1);
        sendOnes(639);
        applyStimulus(1'b1, 1'b1, w);
        checkOutput("sof on last pixel emits nothing", {39'b0, gv0}, 40'd0);
        q0.push_back(ALL1);
        q1.push_back(ALL1);
        sendOnes(639);
        checkOutput("cell after sof-last", {39'b0, gv0}, 40'd1);
        checkOutput("err_cnt after second resync", {32'b0, ec0}, ERR2);

        // Reset with a glyph pending and a partial cell in flight.
        @(posedge ACLK); #1;
        glyph_ready = 1'b0;
        sendOnes(640);
        checkOutput("glyph pending before reset", {39'b0, gv0}, 40'd1);
        sendOnes(300);
        ARESET    = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 1'b1;
        #1;
        checkOutput("mid reset glyph_valid", {39'b0, gv0}, 40'd0);
        checkOutput("mid reset glyph_data", gd0, 40'd0);
        checkOutput("mid reset pix_ready", {39'b0, pix_ready0}, 40'd0);
        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("held reset pix_ready", {39'b0, pix_ready0}, 40'd0);
        pix_valid = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        glyph_ready = 1'b1;
        @(posedge ACLK); #1;
        checkOutput("err_cnt after reset", {32'b0, ec0}, 40'd0);
        sendCell(2, 1'b0, TOPBOT, TOPBOT);

        repeat (5) @(posedge ACLK);
        #1;
        checkOutput("scoreboard drained", 40'(q0.size() + q1.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/char_glyph_packer.md
# char_glyph_packer

Converts a binarized raster pixel stream for one character cell into a packed 40-bit glyph: a 5-column by 8-row grid with one bit per block, decided by a thresholded pixel count. Sits directly upstream of the 40-bit character register block that the Cortex-M3 reads over AXI4-Lite. Accepts pixels on a valid/ready stream and presents finished glyphs through a one-deep output buffer with valid/ready handshake.

## Interface

- BLK_W, 4, pixels per block horizontally; cell width = 5*BLK_W
- BLK_H, 4, pixels per block vertically; cell height = 8*BLK_H
- THRESH, 8, minimum set-pixel count in a block for its bit to be 1; valid range 1..BLK_W*BLK_H

- ACLK  in  1  clock; all logic is rising-edge
- ARESET  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  pixel beat accepted when pix_valid && pix_ready
- pix_data  in  1  binarized pixel, 1 = ink
- pix_sof  in  1  marks the beat as pixel (0,0) of a new cell
- glyph_valid  out  1  glyph_data holds a finished glyph
- glyph_ready  in  1  consumer accepts the glyph
- glyph_data  out  40  packed glyph; bit index = row*5 + col; row 0 is the top, col 0 is the left
- err_cnt  out  8  saturating count of mid-cell SOF resyncs (see Configuration)

## Operation

- Pixels arrive in raster order: columns 0..5*BLK_W-1 within each row, then rows 0..8*BLK_H-1.
- Internal counters:
  - px_col, px_row: pixel position within the cell.
  - Five per-block-column accumulators, each clog2(BLK_W*BLK_H+1) bits wide, for the current band of BLK_H rows.
  - A 40-bit shadow register holding the glyph being assembled.
- Each accepted beat adds pix_data to accumulator px_col/BLK_W.
- On the last pixel of a block (px_col%BLK_W==BLK_W-1 and px_row%BLK_H==BLK_H-1):
  - shadow bit (px_row/BLK_H)*5 + px_col/BLK_W is set to (acc+pix_data >= THRESH);
  - the accumulator is cleared.
- Last pixel of the cell (px_col=5*BLK_W-1, px_row=8*BLK_H-1):
  - the final shadow bits are merged and the full 40-bit value loads into the glyph_data register;
  - glyph_valid is set;
  - counters, accumulators and shadow return to 0.
- Counters wrap automatically, so pix_sof is optional for back-to-back cells.
- pix_sof on an accepted beat:
  - forces that beat to position (0,0);
  - clears accumulators and shadow, discarding any partial cell.
  - If the position was not already (0,0), this is a resync error.
- Output buffer: glyph_valid stays high and glyph_data stays stable until glyph_valid && glyph_ready.
- pix_ready = !ARESET && !(glyph_valid && !glyph_ready && at_last_pixel). Accumulation of the next cell continues while a glyph waits; the stream stalls only on the final pixel.

## Timing

- Reset values: glyph_valid=0, glyph_data=0, err_cnt=0, pix_ready=0 while ARESET is high; all counters, accumulators and shadow are 0.
- Latency: glyph_valid rises on the first ACLK edge after the last pixel is accepted. The glyph is visible the next cycle.
- Simultaneous drain and load: if glyph_valid && glyph_ready in the same cycle the last pixel is accepted, the new glyph loads and glyph_valid stays 1 with no bubble.
- pix_ready is combinational from glyph_valid, glyph_ready and position. It has no dependency on pix_valid.
- Reset mid-cell: the partial cell is lost. After release, the first beat is treated as (0,0) whether or not pix_sof is set.
- pix_sof together with the last-pixel position: pix_sof wins. The beat becomes (0,0) and no glyph is emitted.

## Configuration

- CHAR_GLYPH_PACKER_ERRCNT_EN defined:
  - err_cnt increments on each mid-cell pix_sof resync and saturates at 255.
  - It is cleared only by ARESET.
- Not defined: err_cnt is tied to 0, there is no counter logic, and resync behaviour is otherwise identical.

## Test plan

- All-ones cell: 640 beats of 1 with default parameters -> glyph_data=40'hFF_FFFF_FFFF, glyph_valid one cycle after the last beat, err_cnt=0.
- Threshold boundary:
  - Block (row 0, col 0) has 8 ones, block (row 0, col 1) has 7, everything else 0 -> glyph_data=40'h00_0000_0001.
  - Same cell rebuilt with THRESH=7 -> 40'h00_0000_0003.
- Top-row and bottom-row pattern: ink only in pixel rows 0..3 and 28..31 -> glyph_data=40'hF8_0000_001F.
- Backpressure:
  - glyph_ready held 0 and two cells sent back to back.
  - Required: pix_ready drops only at the second cell's last pixel, and glyph_data holds glyph 1.
  - Raising glyph_ready for one cycle: glyph 1 drains and the stalled pixel is accepted in the same cycle. glyph 2 appears next cycle with no bubble.
- Mid-cell resync: pix_sof asserted at pixel 100 of a cell, then a full all-ones cell sent -> one glyph 40'hFF_FFFF_FFFF, and err_cnt=1 with the macro defined or 0 without it.
- Reset mid-operation:
  - ARESET pulsed at pixel 300 -> glyph_valid=0 and pix_ready=0 during reset.
  - After release, a full cell without pix_sof produces the correct glyph.
